data_mem_ctrl: RTL

//  Parametrised data memory for the RISC-V core's MEM stage. It is byte-addressed and

---
 rtl/data_mem_ctrl_if.sv | 26 ++
 rtl/data_mem_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between the LSU (master) and the data memory controller (slave).
interface data_mem_ctrl_if #(
    parameter int unsigned ADDR_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [63:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [63:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Byte-addressed little-endian data memory with 64-bit words, sized loads/stores,
// error reporting, valid/ready handshake and zero-initialisation after reset.
module data_mem_ctrl #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_ctrl_if.slave       bus,
    output logic                 init_done
);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {StInit, StIdle, StResp} state_e;

    state_e            state_q;
    logic [IDX_W-1:0]  idx_q;
    logic              resp_valid_q;
    logic [63:0]       rdata_q;
    logic              err_q;
    logic              init_done_q;

    logic [63:0]       mem [DEPTH];

    logic [ADDR_W-1:0] addr;
    logic [IDX_W-1:0]  wi;
    logic [2:0]        lane;
    logic              oob;
    logic              misalign;
    logic              err;
    logic              accept;
    logic [7:0]        size_mask;
    logic [7:0]        store_be;
    logic [63:0]       store_data;
    logic [63:0]       shifted;
    logic              sx;
    logic [63:0]       load_data;
    logic [63:0]       resp_data;

    logic              mem_we;
    logic [IDX_W-1:0]  mem_idx;
    logic [7:0]        mem_be;
    logic [63:0]       mem_wdata;

    assign addr     = bus.req_addr;
    assign wi       = addr[3 +: IDX_W];
    assign lane     = addr[2:0];
    assign oob      = |addr[ADDR_W-1:3+IDX_W];
    assign err      = misalign | oob;
    assign accept   = bus.req_valid & bus.req_ready;
    assign sx       = ~bus.req_unsigned;
    assign shifted  = mem[wi] >> {lane, 3'b000};
    assign store_be   = size_mask << lane;
    assign store_data = bus.req_wdata << {lane, 3'b000};
    assign resp_data  = (err | bus.req_we) ? 64'd0 : load_data;

    always_comb begin
        size_mask = 8'h00;
        misalign  = 1'b0;
        load_data = 64'd0;
        unique case (bus.req_size)
            2'b00: begin
                size_mask = 8'h01;
                misalign  = 1'b0;
                load_data = {{56{sx & shifted[7]}}, shifted[7:0]};
            end
            2'b01: begin
                size_mask = 8'h03;
                misalign  = addr[0];
                load_data = {{48{sx & shifted[15]}}, shifted[15:0]};
            end
            2'b10: begin
                size_mask = 8'h0f;
                misalign  = |addr[1:0];
                load_data = {{32{sx & shifted[31]}}, shifted[31:0]};
            end
            default: begin
                size_mask = 8'hff;
                misalign  = |addr[2:0];
                load_data = shifted;
            end
        endcase
    end

    always_comb begin
        bus.req_ready = 1'b0;
        unique case (state_q)
            StIdle:  bus.req_ready = 1'b1;
            StResp:  bus.req_ready = bus.resp_ready;
            default: bus.req_ready = 1'b0;
        endcase
    end

    // Init sweep and stores share one write port; reset suppresses any write on its edge.
    always_comb begin
        mem_we    = 1'b0;
        mem_idx   = wi;
        mem_be    = store_be;
        mem_wdata = store_data;
        if (state_q == StInit) begin
            mem_we    = ~rst;
            mem_idx   = idx_q;
            mem_be    = 8'hff;
            mem_wdata = 64'd0;
        end else if (accept && bus.req_we && !err) begin
            mem_we    = ~rst;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StInit;
            idx_q        <= '0;
            resp_valid_q <= 1'b0;
            rdata_q      <= 64'd0;
            err_q        <= 1'b0;
            init_done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StInit: begin
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == IDX_W'(DEPTH - 1)) begin
                        state_q     <= StIdle;
                        init_done_q <= 1'b1;
                    end
                end
                StIdle: begin
                    if (accept) begin
                        state_q      <= StResp;
                        resp_valid_q <= 1'b1;
                        rdata_q      <= resp_data;
                        err_q        <= err;
                    end
                end
                StResp: begin
                    if (bus.resp_ready) begin
                        if (bus.req_valid) begin
                            rdata_q <= resp_data;
                            err_q   <= err;
                        end else begin
                            state_q      <= StIdle;
                            resp_valid_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= StInit;
            endcase
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign init_done      = init_done_q;
endmodule
